sie_tx_ctrl: RTL and testbench
==============================

SIE_TX_CTRL -- requirements
Module: sie_tx_ctrl

Interface
REQ-001 Parameter MAX_PKT, default 64: maximum data-payload bytes per DATA packet, range 1..1023.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and reset_n.
REQ-003 clk  input  1  USB clock; every flop is rising-edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 usb_reset  input  1  USB bus reset from the PHY; synchronous abort.
REQ-006 send_req  input  1  one-cycle request to transmit a packet; sampled only in IDLE.
REQ-007 pid  input  4  packet ID; sampled with send_req.
REQ-008 busy  output  1  high from the cycle after send_req acceptance until return to IDLE.
REQ-009 done  output  1  one-cycle pulse when the last byte has been accepted by the PHY.
REQ-010 fifo_q  input  8  show-ahead FIFO head; valid while fifo_empty=0.
REQ-011 fifo_empty  input  1  payload FIFO empty.
REQ-012 fifo_rdreq  output  1  combinational pop, at most one pulse per accepted payload byte.
REQ-013 tx_data  output  8  byte to the PHY.
REQ-014 tx_valid  output  1  rise starts SYNC, high while sending, fall triggers EOP.
REQ-015 tx_ready  input  1  one-cycle pulse: the current tx_data has been consumed by the PHY.

Function
REQ-016 States: IDLE, PID, DATA, CRC_LO, CRC_HI, EOP.
REQ-017 IDLE with send_req=1: next edge latches pid, loads tx_data={~pid,pid}, sets tx_valid=1, and enters PID.
REQ-018 PID byte examples: ACK 0x2 -> 0xD2; DATA0 0x3 -> 0xC3; DATA1 0xB -> 0x4B.
REQ-019 A packet is a data packet iff pid[1:0]==2'b11; any other PID is PID-only.
REQ-020 tx_data and tx_valid are registered and change only on a tx_ready cycle, except at the start (REQ-017) and on abort (REQ-030).
REQ-021 PID on tx_ready, PID-only packet: tx_valid<=0, done=1, go to EOP.
REQ-022 PID on tx_ready, data packet with fifo_empty=0: tx_data<=fifo_q, fifo_rdreq=1 in the same cycle, byte count<=1, go to DATA.
REQ-023 PID on tx_ready, data packet with fifo_empty=1 (zero-length): tx_data<=0x00, go to CRC_LO.
REQ-024 DATA on tx_ready: CRC is updated with the current tx_data.
  - If byte count<MAX_PKT and fifo_empty=0: load fifo_q, pulse fifo_rdreq, increment byte count.
  - Otherwise: tx_data<=~crc_next[7:0], go to CRC_LO.
REQ-025 CRC_LO on tx_ready: tx_data<=~crc[15:8], go to CRC_HI.
REQ-026 CRC_HI on tx_ready: tx_valid<=0, done=1, go to EOP.
REQ-027 EOP lasts exactly one cycle (tx_valid=0, busy=1), then IDLE, guaranteeing a minimum one-cycle tx_valid low gap.
REQ-028 CRC16 rules:
  - Reflected polynomial 0xA001 (USB 0x8005), LSB-first.
  - Initialised to 0xFFFF on send_req acceptance.
  - Covers payload bytes only.
  - Transmitted complemented, low byte first.
REQ-029 Byte count is 11 bits; it saturates at MAX_PKT, and FIFO bytes beyond MAX_PKT remain unread for the next packet.
REQ-030 usb_reset=1 in any state:
  - Next edge: IDLE, tx_valid=0, busy=0.
  - No done and no fifo_rdreq in that cycle.
  - send_req is ignored while usb_reset=1.
REQ-031 send_req outside IDLE is ignored; tx_ready outside PID/DATA/CRC_LO/CRC_HI is ignored.
REQ-032 fifo_empty rising mid-DATA ends the payload at the bytes already sent; this is not an error.

Reset
REQ-033 On reset_n=0, asynchronously:
  - State IDLE.
  - tx_data=0x00, tx_valid=0, busy=0, done=0, fifo_rdreq=0.
  - CRC=0xFFFF, byte count=0.
REQ-034 Deassertion of reset_n takes effect on the next clk edge; no transmission starts without a new send_req.

Verification
REQ-035 send_req with pid=0x2 -> tx_data 0xD2 with tx_valid=1; after one tx_ready: tx_valid=0, done pulse, busy low 2 cycles later.
REQ-036 Empty FIFO, pid=0x3 -> byte sequence C3,00,00; exactly 3 tx_ready handshakes; fifo_rdreq never asserted.
REQ-037 FIFO holds 00,01,02,03 and pid=0xB -> sequence 4B,00,01,02,03,crcL,crcH matching a bit-serial CRC16 model; exactly 4 fifo_rdreq pulses.
REQ-038 MAX_PKT=4 with 6 bytes in the FIFO -> 4 payload bytes sent plus CRC; 2 bytes remain in the FIFO; byte count=4.
REQ-039 usb_reset asserted mid-DATA -> next cycle IDLE, tx_valid=0, no done; a subsequent send_req pid=0x2 transmits 0xD2 correctly.
REQ-040 reset_n pulsed low mid-CRC_LO, asynchronously between edges -> all outputs reach reset values immediately, with no further fifo_rdreq.

Source files
------------

// File: rtl/sie_tx_ctrl_if.sv
// Handshake bundle between the USB SIE transmit controller, its payload FIFO and the PHY.
// The master side drives requests, FIFO status and tx_ready; the slave is the controller.
interface sie_tx_ctrl_if;
    logic       usb_reset;
    logic       send_req;
    logic [3:0] pid;
    logic       busy;
    logic       done;
    logic [7:0] fifo_q;
    logic       fifo_empty;
    logic       fifo_rdreq;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output usb_reset, send_req, pid, fifo_q, fifo_empty, tx_ready,
        input  busy, done, fifo_rdreq, tx_data, tx_valid
    );

    modport slave (
        input  usb_reset, send_req, pid, fifo_q, fifo_empty, tx_ready,
        output busy, done, fifo_rdreq, tx_data, tx_valid
    );
endinterface

// File: rtl/sie_tx_ctrl.sv
// USB SIE transmit sequencer: PID byte, optional FIFO payload capped at MAX_PKT bytes,
// complemented CRC16 trailer, then a one-cycle EOP gap before the next packet.
module sie_tx_ctrl #(
    parameter int MAX_PKT = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    sie_tx_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PID, DATA, CRC_LO, CRC_HI, EOP} state_t;

    localparam logic [10:0] MAX_CNT = 11'(MAX_PKT);

    state_t      state;
    logic        data_pkt;
    logic [15:0] crc;
    logic [15:0] crc_next;
    logic [10:0] byte_cnt;
    logic        more;

    // Reflected USB CRC16, data consumed LSB first.
    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    assign crc_next = crc16_upd(crc, bus.tx_data);
    assign more     = (byte_cnt < MAX_CNT) && !bus.fifo_empty;

    // Pop only in the cycle the PHY takes a byte and the FIFO head becomes the next one.
    always_comb begin
        bus.fifo_rdreq = 1'b0;
        if (!bus.usb_reset && bus.tx_ready) begin
            case (state)
                PID:     bus.fifo_rdreq = data_pkt && !bus.fifo_empty;
                DATA:    bus.fifo_rdreq = more;
                default: bus.fifo_rdreq = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            data_pkt    <= 1'b0;
            crc         <= 16'hFFFF;
            byte_cnt    <= '0;
            bus.tx_data <= 8'h00;
            bus.tx_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.usb_reset) begin
                state        <= IDLE;
                bus.tx_data  <= 8'h00;
                bus.tx_valid <= 1'b0;
                bus.busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.send_req) begin
                        data_pkt     <= (bus.pid[1:0] == 2'b11);
                        bus.tx_data  <= {~bus.pid, bus.pid};
                        bus.tx_valid <= 1'b1;
                        bus.busy     <= 1'b1;
                        crc          <= 16'hFFFF;
                        byte_cnt     <= '0;
                        state        <= PID;
                    end
                    PID: if (bus.tx_ready) begin
                        if (!data_pkt) begin
                            bus.tx_valid <= 1'b0;
                            bus.done     <= 1'b1;
                            state        <= EOP;
                        end else if (!bus.fifo_empty) begin
                            bus.tx_data <= bus.fifo_q;
                            byte_cnt    <= 11'd1;
                            state       <= DATA;
                        end else begin
                            // Zero-length payload: ~0xFFFF low byte is 0x00.
                            bus.tx_data <= 8'h00;
                            state       <= CRC_LO;
                        end
                    end
                    DATA: if (bus.tx_ready) begin
                        crc <= crc_next;
                        if (more) begin
                            bus.tx_data <= bus.fifo_q;
                            byte_cnt    <= byte_cnt + 11'd1;
                        end else begin
                            bus.tx_data <= ~crc_next[7:0];
                            state       <= CRC_LO;
                        end
                    end
                    CRC_LO: if (bus.tx_ready) begin
                        bus.tx_data <= ~crc[15:8];
                        state       <= CRC_HI;
                    end
                    CRC_HI: if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= EOP;
                    end
                    EOP: begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sie_tx_ctrl.sv
// Bench for sie_tx_ctrl: two instances (MAX_PKT 64 and 4) share one modelled FIFO;
// each packet's byte stream is predicted from the PID rule, payload cap and a CRC16 model.
module tb_sie_tx_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       usb_reset = 1'b0;
    logic       send_req = 1'b0;
    logic       tx_ready = 1'b0;
    logic [3:0] pid = 4'h0;
    bit         sel = 1'b0;

    logic [7:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         rd_cnt = 0;
    logic [7:0] fifo_q;
    logic       fifo_empty;
    assign fifo_q     = mem[rd_ptr % 1024];
    assign fifo_empty = (rd_ptr == wr_ptr);

    sie_tx_ctrl_if i0 ();
    sie_tx_ctrl_if i1 ();

    assign i0.usb_reset  = usb_reset;
    assign i0.send_req   = send_req & ~sel;
    assign i0.pid        = pid;
    assign i0.tx_ready   = tx_ready & ~sel;
    assign i0.fifo_q     = fifo_q;
    assign i0.fifo_empty = fifo_empty | sel;
    assign i1.usb_reset  = usb_reset;
    assign i1.send_req   = send_req & sel;
    assign i1.pid        = pid;
    assign i1.tx_ready   = tx_ready & sel;
    assign i1.fifo_q     = fifo_q;
    assign i1.fifo_empty = fifo_empty | ~sel;

    sie_tx_ctrl #(.MAX_PKT(64)) dut0 (.clk(clk), .reset_n(reset_n), .bus(i0.slave));
    sie_tx_ctrl #(.MAX_PKT(4))  dut1 (.clk(clk), .reset_n(reset_n), .bus(i1.slave));

    logic [7:0] o_tx_data;
    logic       o_tx_valid, o_busy, o_done, o_rdreq;
    assign o_tx_data  = sel ? i1.tx_data    : i0.tx_data;
    assign o_tx_valid = sel ? i1.tx_valid   : i0.tx_valid;
    assign o_busy     = sel ? i1.busy       : i0.busy;
    assign o_done     = sel ? i1.done       : i0.done;
    assign o_rdreq    = sel ? i1.fifo_rdreq : i0.fifo_rdreq;

    always @(posedge clk) begin
        if (o_rdreq === 1'b1) begin
            rd_ptr <= rd_ptr + 1;
            rd_cnt <= rd_cnt + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 1024] = b;
        wr_ptr++;
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    task automatic ready_pulse();
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    // Full packet: predict bytes, then drive it with random PHY stalls and stray send_req.
    task automatic run_pkt(input bit s, input logic [3:0] p, input string tag);
        logic [7:0]  exp[$];
        logic [7:0]  got[$];
        logic [15:0] c;
        logic [7:0]  b;
        int avail, maxp, n, rd0, cyc, dones;
        @(negedge clk);
        sel   = s;
        maxp  = s ? 4 : 64;
        avail = wr_ptr - rd_ptr;
        n     = 0;
        exp.push_back({~p, p});
        if (p[1:0] == 2'b11) begin
            n = (avail < maxp) ? avail : maxp;
            c = 16'hFFFF;
            for (int i = 0; i < n; i++) begin
                b = mem[(rd_ptr + i) % 1024];
                exp.push_back(b);
                c = crc_byte(c, b);
            end
            exp.push_back(~c[7:0]);
            exp.push_back(~c[15:8]);
        end
        rd0 = rd_cnt;
        dones = 0;
        send_req = 1'b1;
        pid = p;
        @(negedge clk);
        send_req = 1'b0;
        chk({tag, "_start_valid"}, 16'(o_tx_valid), 16'd1);
        chk({tag, "_start_busy"}, 16'(o_busy), 16'd1);
        cyc = 0;
        while (o_tx_valid === 1'b1 && cyc < 400) begin
            repeat ($urandom_range(0, 2)) begin
                send_req = ($urandom_range(0, 3) == 0);
                pid = 4'($urandom);
                @(negedge clk);
                send_req = 1'b0;
                cyc++;
                if (o_done === 1'b1) dones++;
            end
            got.push_back(o_tx_data);
            ready_pulse();
            cyc++;
            if (o_done === 1'b1) dones++;
        end
        chk({tag, "_valid_fell"}, 16'(o_tx_valid), 16'd0);
        chk({tag, "_eop_busy"}, 16'(o_busy), 16'd1);
        chk({tag, "_done_count"}, 16'(dones), 16'd1);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk({tag, "_idle_busy"}, 16'(o_busy), 16'd0);
        chk({tag, "_idle_done"}, 16'(o_done), 16'd0);
        chk({tag, "_nbytes"}, 16'(got.size()), 16'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 16'(got[i]), 16'(exp[i]));
        chk({tag, "_rdreq_count"}, 16'(rd_cnt - rd0), 16'(n));
    endtask

    initial begin
        int rd0, k;
        bit s;
        logic [3:0] p;

        #2;
        chk("rst_tx_data", 16'(i0.tx_data), 16'h00);
        chk("rst_tx_valid", 16'(i0.tx_valid), 16'd0);
        chk("rst_busy", 16'(i0.busy), 16'd0);
        chk("rst_done", 16'(i0.done), 16'd0);
        chk("rst_rdreq", 16'(i0.fifo_rdreq), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 16'(o_tx_valid), 16'd0);

        run_pkt(1'b0, 4'h2, "ack");
        run_pkt(1'b0, 4'h3, "zlp");
        for (int i = 0; i < 4; i++) push(8'(i));
        run_pkt(1'b0, 4'hB, "data1_4");
        for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
        run_pkt(1'b1, 4'h3, "max4");
        chk("max4_left", 16'(wr_ptr - rd_ptr), 16'd2);
        run_pkt(1'b1, 4'hB, "max4_rest");

        // Bus reset while in DATA
        for (int i = 0; i < 10; i++) push(8'(8'h30 + i));
        @(negedge clk);
        sel = 1'b0;
        send_req = 1'b1;
        pid = 4'h3;
        @(negedge clk);
        send_req = 1'b0;
        ready_pulse();
        chk("abort_byte0", 16'(o_tx_data), 16'h30);
        ready_pulse();
        chk("abort_byte1", 16'(o_tx_data), 16'h31);
        rd0 = rd_cnt;
        usb_reset = 1'b1;
        tx_ready = 1'b1;
        send_req = 1'b1;
        pid = 4'h2;
        #1;
        chk("abort_rdreq", 16'(o_rdreq), 16'd0);
        @(negedge clk);
        tx_ready = 1'b0;
        chk("abort_valid", 16'(o_tx_valid), 16'd0);
        chk("abort_busy", 16'(o_busy), 16'd0);
        chk("abort_done", 16'(o_done), 16'd0);
        @(negedge clk);
        send_req = 1'b0;
        usb_reset = 1'b0;
        chk("abort_sendreq_ignored", 16'(o_busy), 16'd0);
        chk("abort_no_pop", 16'(rd_cnt - rd0), 16'd0);
        run_pkt(1'b0, 4'h2, "after_abort");

        // Asynchronous reset while the CRC low byte is on the bus
        @(negedge clk);
        send_req = 1'b1;
        pid = 4'hB;
        @(negedge clk);
        send_req = 1'b0;
        repeat (9) ready_pulse();
        chk("crclo_valid", 16'(o_tx_valid), 16'd1);
        rd0 = rd_cnt;
        tx_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tx_data", 16'(o_tx_data), 16'h00);
        chk("arst_valid", 16'(o_tx_valid), 16'd0);
        chk("arst_busy", 16'(o_busy), 16'd0);
        chk("arst_done", 16'(o_done), 16'd0);
        chk("arst_rdreq", 16'(o_rdreq), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_stays_idle", 16'(o_tx_valid), 16'd0);
        chk("arst_no_busy", 16'(o_busy), 16'd0);
        chk("arst_no_pop", 16'(rd_cnt - rd0), 16'd0);

        for (int it = 0; it < 24; it++) begin
            s = 1'($urandom_range(0, 1));
            p = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) p[1:0] = 2'b11;
            k = $urandom_range(0, s ? 7 : 70);
            if (wr_ptr - rd_ptr > 600) k = 0;
            for (int j = 0; j < k; j++) push(8'($urandom));
            run_pkt(s, p, $sformatf("rnd%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
